cache_access_ctrl: RTL and testbench
====================================

# cache_access_ctrl

Request-side controller for the two-level cache hit-detection block. It accepts one address at a time from a requester over a Req/Ack handshake, drives the cache's Add/Strobe inputs, samples the returned Hit code a fixed number of cycles later, and models the service penalty of the level that hit. It then signals completion and keeps saturating hit/miss statistics. It therefore sits directly upstream of the cache, feeding Add/Strobe, and directly downstream of it, consuming Hit.

## Interface
- HIT_LAT, 2, cycles from the cache sampling Strobe to Hit being valid (≥1)
- L2_PEN, 4, extra cycles charged for an L2 hit (≥1)
- MEM_PEN, 20, extra cycles charged for a miss (≥1, ≥ L2_PEN)
- CNT_W, 16, statistics counter width

- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Req  in  1  requester holds high until Ack
- ReqAdd  in  16  request address, valid while Req=1
- ClrCnt  in  1  synchronous clear of all statistics counters
- Hit  in  2  cache result: 2'b00 miss, 2'b01 L1 hit, 2'b10 L2 hit, 2'b11 illegal
- Add  out  16  address to cache
- Strobe  out  1  one-cycle lookup strobe to cache
- Ack  out  1  one-cycle pulse, request accepted
- Busy  out  1  access in progress
- Done  out  1  one-cycle completion pulse
- Level  out  2  Hit code of the completed access, valid with Done
- Err  out  1  sticky, set on Hit=2'b11
- L1Cnt, L2Cnt, MissCnt  out  CNT_W each  saturating event counters

## Operation
- States: IDLE, LOOKUP, PENALTY, DONE. All outputs are registered.
- IDLE: Busy=0. On Req=1 at an edge:
  - Add<=ReqAdd, Strobe<=1, Ack<=1, Busy<=1.
  - Load the timer with HIT_LAT, go to LOOKUP.
- LOOKUP: Strobe and Ack drop after one cycle. The timer decrements each cycle. When it expires, Hit is sampled:
  - 01: L1Cnt++, go to DONE.
  - 10: L2Cnt++, load the timer with L2_PEN, go to PENALTY.
  - 00: MissCnt++, load the timer with MEM_PEN, go to PENALTY.
  - 11: MissCnt++, Err<=1, treated as a miss.
- PENALTY: count down, then go to DONE.
- DONE: Done=1 and Level=the sampled code for exactly one cycle; Busy is still 1. Next state is IDLE.
- Level holds its value until the next Done. Add holds stable from Strobe through Done.
- Req is ignored outside IDLE. A Req present in the DONE cycle is accepted on the first IDLE edge, so back-to-back accesses have a 1-cycle IDLE gap.
- Counters saturate at all-ones. If ClrCnt coincides with an increment, the clear wins. ClrCnt does not clear Err.
- Err is cleared only by reset.

## Timing
- Reset (async assert, sync deassert upstream):
  - State=IDLE.
  - Add=0, Strobe=0, Ack=0, Busy=0, Done=0, Level=0, Err=0.
  - All counters 0.
- Reset mid-access aborts the access; no Done is produced and counters are not incremented.
- With acceptance at edge k:
  - Strobe is high in cycle k..k+1 and is sampled by the cache at edge k+1.
  - Hit is sampled at edge k+1+HIT_LAT.
  - Done is registered at edge k+1+HIT_LAT+P, where P=0 (L1), L2_PEN (L2) or MEM_PEN (miss).
- With defaults, Done arrives 3, 7 or 23 edges after acceptance.
- Throughput is one access per (HIT_LAT+P+3) cycles.
- The timer width is sized from max(HIT_LAT, MEM_PEN).

## Structure
- Shared package cache_pkg holds:
  - Hit code constants HIT_MISS, HIT_L1, HIT_L2, HIT_ILL.
  - The state enum type.
  - The address width of 16.
- Sub-module sat_counter (param W; inputs inc and clr, clr priority; output cnt) is instantiated three times.
- The FSM, timer and output registers live in the top module.

## Test plan
- Reset then Req=1, ReqAdd=16'h1234, cache returns Hit=01 at the sample edge -> single Strobe with Add=16'h1234, Done 3 edges after Ack, Level=01, L1Cnt=1.
- Hit=10 -> Done 7 edges after Ack, Level=10, L2Cnt=1. Hit=00 -> Done 23 edges after Ack, MissCnt=1.
- Req held continuously for 3 accesses -> exactly 3 Ack pulses, each Ack only from IDLE, a 1-cycle gap after each Done, and Add stable through each access.
- Hit=11 -> Err=1 and stays high through later accesses, MissCnt increments, Level=11 with Done.
- CNT_W=2, five L1 hits -> L1Cnt stays 3. ClrCnt asserted on the edge of a hit -> L1Cnt=0.
- Rst_n asserted during PENALTY -> all outputs 0 immediately, no Done. The next Req after release completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache request-side controller: hit codes, FSM states, address width.
// No logic; imported by the controller and its sub-modules.
package cache_pkg;

    localparam int ADDR_W = 16;

    localparam logic [1:0] HIT_MISS = 2'b00;
    localparam logic [1:0] HIT_L1   = 2'b01;
    localparam logic [1:0] HIT_L2   = 2'b10;
    localparam logic [1:0] HIT_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_PENALTY,
        ST_DONE
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, registered output, clear has priority over increment.
// Updates one edge after inc/clr; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_access_ctrl.sv
// Request-side cache controller: Req/Ack intake, Add/Strobe to cache, Hit sampling, penalty timing, stats.
// Done 1+HIT_LAT+P edges after Ack; one access in flight, Req is held off (ignored) until the FSM is back in IDLE.
module cache_access_ctrl
    import cache_pkg::*;
#(
    parameter int HIT_LAT = 2,
    parameter int L2_PEN  = 4,
    parameter int MEM_PEN = 20,
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req,
    input  logic [ADDR_W-1:0] ReqAdd,
    input  logic              ClrCnt,
    input  logic [1:0]        Hit,
    output logic [ADDR_W-1:0] Add,
    output logic              Strobe,
    output logic              Ack,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        Level,
    output logic              Err,
    output logic [CNT_W-1:0]  L1Cnt,
    output logic [CNT_W-1:0]  L2Cnt,
    output logic [CNT_W-1:0]  MissCnt
);

    localparam int TW = $clog2(max_int(HIT_LAT, MEM_PEN) + 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic              strobe_q, strobe_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        level_q, level_d;
    logic [1:0]        code_q, code_d;
    logic              tmr_zero, sample;
    logic              inc_l1, inc_l2, inc_miss;

    assign tmr_zero = (tmr_q == '0);
    assign sample   = (state_q == ST_LOOKUP) && tmr_zero;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (Req) state_d = ST_LOOKUP;
            ST_LOOKUP:  if (tmr_zero) state_d = (Hit == HIT_L1) ? ST_DONE : ST_PENALTY;
            ST_PENALTY: if (tmr_zero) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Penalty loads P-1 so Done lands exactly P edges after the Hit sample edge.
    always_comb begin
        add_d    = add_q;
        strobe_d = 1'b0;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        level_d  = level_q;
        err_d    = err_q;
        code_d   = code_q;
        tmr_d    = tmr_zero ? tmr_q : tmr_q - TW'(1);
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    add_d    = ReqAdd;
                    strobe_d = 1'b1;
                    ack_d    = 1'b1;
                    busy_d   = 1'b1;
                    tmr_d    = TW'(HIT_LAT);
                end
            end
            ST_LOOKUP: begin
                if (tmr_zero) begin
                    code_d = Hit;
                    case (Hit)
                        HIT_L1: begin
                            done_d  = 1'b1;
                            level_d = Hit;
                        end
                        HIT_L2:  tmr_d = TW'(L2_PEN - 1);
                        default: begin
                            tmr_d = TW'(MEM_PEN - 1);
                            if (Hit == HIT_ILL) err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_PENALTY: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    level_d = code_q;
                end
            end
            ST_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmr_q    <= '0;
            add_q    <= '0;
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            level_q  <= 2'b00;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            tmr_q    <= tmr_d;
            add_q    <= add_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            level_q  <= level_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // An illegal code is counted as a miss.
    assign inc_l1   = sample && (Hit == HIT_L1);
    assign inc_l2   = sample && (Hit == HIT_L2);
    assign inc_miss = sample && ((Hit == HIT_MISS) || (Hit == HIT_ILL));

    sat_counter #(.W(CNT_W)) u_l1_cnt (
        .Clk(Clk), .Rst_n(Rst_n), .inc(inc_l1), .clr(ClrCnt), .cnt(L1Cnt)
    );

    sat_counter #(.W(CNT_W)) u_l2_cnt (
        .Clk(Clk), .Rst_n(Rst_n), .inc(inc_l2), .clr(ClrCnt), .cnt(L2Cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .Clk(Clk), .Rst_n(Rst_n), .inc(inc_miss), .clr(ClrCnt), .cnt(MissCnt)
    );

    assign Add    = add_q;
    assign Strobe = strobe_q;
    assign Ack    = ack_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Level  = level_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Scoreboard bench for cache_access_ctrl: random accesses against an access-level reference model.
module tb_cache_access_ctrl;
    import cache_pkg::*;

    localparam int HIT_LAT = 2;
    localparam int L2_PEN  = 4;
    localparam int MEM_PEN = 20;
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             Clk    = 1'b0;
    logic             Rst_n  = 1'b1;
    logic             Req    = 1'b0;
    logic [15:0]      ReqAdd = '0;
    logic             ClrCnt = 1'b0;
    logic [1:0]       Hit    = 2'b00;
    logic [15:0]      Add;
    logic             Strobe, Ack, Busy, Done, Err;
    logic [1:0]       Level;
    logic [CNT_W-1:0] L1Cnt, L2Cnt, MissCnt;

    cache_access_ctrl #(
        .HIT_LAT(HIT_LAT), .L2_PEN(L2_PEN), .MEM_PEN(MEM_PEN), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqAdd(ReqAdd), .ClrCnt(ClrCnt), .Hit(Hit),
        .Add(Add), .Strobe(Strobe), .Ack(Ack), .Busy(Busy), .Done(Done), .Level(Level),
        .Err(Err), .L1Cnt(L1Cnt), .L2Cnt(L2Cnt), .MissCnt(MissCnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] add;
        logic [1:0]  code;
        int          req_edge;
        int          l1, l2, miss;
        bit          err;
    } rec_t;

    rec_t       exp_q[$];
    logic [1:0] code_q[$];
    int         n_checks = 0, n_errors = 0;
    int         m_l1 = 0, m_l2 = 0, m_miss = 0;
    bit         m_err = 0;
    int         last_done = -100, ack_cyc = 0, n_ack = 0, n_ack_exp = 0;
    logic [1:0] held_level = 2'b00;
    logic [15:0] cur_add = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int pen(input logic [1:0] c);
        if (c == HIT_L1) return 0;
        if (c == HIT_L2) return L2_PEN;
        return MEM_PEN;
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // Cache model: returns the planned code exactly HIT_LAT edges after it samples Strobe, noise otherwise.
    logic [1:0] pend_code = 2'b00;
    int         pend_cyc  = 0;
    bit         pend      = 0;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            pend = 0;
            Hit  = 2'($urandom);
        end else begin
            if (Strobe) begin
                if (code_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cache_strobe: unexpected Strobe with Add=0x%0h, expected none", Add);
                end else begin
                    pend_code = code_q.pop_front();
                    pend_cyc  = cyc + HIT_LAT;
                    pend      = 1;
                end
            end
            if (pend && cyc == pend_cyc) begin
                Hit  = pend_code;
                pend = 0;
            end else begin
                Hit = 2'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Strobe || Ack) check("strobe_eq_ack", Strobe, Ack);
            if (Ack) begin
                n_ack++;
                ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", Ack, 0);
                end else begin
                    check("ack_cycle", cyc, (exp_q[0].req_edge > last_done + 2) ? exp_q[0].req_edge : last_done + 2);
                    check("ack_add", Add, exp_q[0].add);
                    cur_add = exp_q[0].add;
                end
            end
            if (Busy) check("add_stable", Add, cur_add);
            if (cyc == last_done + 1) begin
                check("gap_busy", Busy, 0);
                check("gap_done", Done, 0);
            end
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", Done, 0);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    check("done_level", Level, r.code);
                    check("done_latency", cyc - ack_cyc, 1 + HIT_LAT + pen(r.code));
                    check("done_l1cnt", L1Cnt, r.l1);
                    check("done_l2cnt", L2Cnt, r.l2);
                    check("done_misscnt", MissCnt, r.miss);
                    check("done_err", Err, r.err);
                    check("done_busy", Busy, 1);
                    held_level = r.code;
                end
                last_done = cyc;
            end else begin
                check("level_hold", Level, held_level);
            end
        end
    end

    task automatic do_access(input logic [15:0] a, input logic [1:0] c, input bit keep, input bit clr_co);
        rec_t r;
        int   t;
        Req    = 1'b1;
        ReqAdd = a;
        code_q.push_back(c);
        if (clr_co) begin
            m_l1 = 0; m_l2 = 0; m_miss = 0;
        end else if (c == HIT_L1) m_l1 = sat(m_l1);
        else if (c == HIT_L2) m_l2 = sat(m_l2);
        else m_miss = sat(m_miss);
        if (c == HIT_ILL) m_err = 1;
        r.add = a; r.code = c; r.req_edge = cyc + 1;
        r.l1 = m_l1; r.l2 = m_l2; r.miss = m_miss; r.err = m_err;
        exp_q.push_back(r);
        n_ack_exp++;
        t = 0;
        do begin
            @(posedge Clk); #1;
            t++;
        end while (!Ack && t < 200);
        if (!Ack) check("ack_timeout", 0, 1);
        if (!keep) Req = 1'b0;
        if (clr_co) begin
            repeat (HIT_LAT) @(posedge Clk);
            #1 ClrCnt = 1'b1;
            @(posedge Clk); #1;
            ClrCnt = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(posedge Clk); #1;
            t++;
        end while (Busy && t < 200);
        if (Busy) check("idle_timeout", Busy, 0);
    endtask

    task automatic idle_clr();
        ClrCnt = 1'b1;
        m_l1 = 0; m_l2 = 0; m_miss = 0;
        @(posedge Clk); #1;
        ClrCnt = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_add"}, Add, 0);
        check({tag, "_strobe"}, Strobe, 0);
        check({tag, "_ack"}, Ack, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_level"}, Level, 0);
        check({tag, "_err"}, Err, 0);
        check({tag, "_l1cnt"}, L1Cnt, 0);
        check({tag, "_l2cnt"}, L2Cnt, 0);
        check({tag, "_misscnt"}, MissCnt, 0);
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        do_access(16'h1234, HIT_L1, 0, 0);
        do_access(16'($urandom), HIT_L2, 0, 0);
        do_access(16'($urandom), HIT_MISS, 0, 0);
        wait_idle();

        do_access(16'hA001, HIT_L1, 1, 0);
        do_access(16'hA002, HIT_L2, 1, 0);
        do_access(16'hA003, HIT_MISS, 0, 0);
        wait_idle();

        do_access(16'hBEEF, HIT_ILL, 0, 0);
        do_access(16'h0042, HIT_L1, 0, 0);
        for (int i = 0; i < 5; i++) do_access(16'($urandom), HIT_L1, 0, 0);
        do_access(16'($urandom), HIT_L1, 0, 1);
        wait_idle();
        idle_clr();

        do_access(16'h5555, HIT_MISS, 0, 0);
        repeat (8) @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        code_q.delete();
        m_l1 = 0; m_l2 = 0; m_miss = 0; m_err = 0;
        last_done  = -100;
        held_level = 2'b00;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(posedge Clk); #1;
        do_access(16'h6666, HIT_L2, 0, 0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            logic [1:0] c;
            bit keep, clr_co;
            c      = 2'($urandom_range(0, 3));
            keep   = (i < 39) && ($urandom_range(0, 2) == 0);
            clr_co = !keep && ($urandom_range(0, 5) == 0);
            do_access(16'($urandom), c, keep, clr_co);
            if (!keep && $urandom_range(0, 4) == 0) begin
                wait_idle();
                idle_clr();
            end
        end
        wait_idle();
        repeat (3) @(posedge Clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("ack_count", n_ack, n_ack_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 2000000 time units");
        $fatal(1);
    end

endmodule
